// File: rtl/sd_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sd_ctrl_pkg
// Description : Shared types and constants for the SD command transfer
//               controller (FSM state encoding, frame/response geometry).
// Revision    : 1.0 - initial release
// ============================================================================
package sd_ctrl_pkg;

    // Default transaction geometry
    localparam int SD_CMD_BYTES = 6;
    localparam int SD_RESP_BITS = 48;
    localparam int SD_NCR_MAX   = 64;

    // Transaction sequencer states
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND      = 3'd1,
        WAIT_RESP = 3'd2,
        RECV      = 3'd3,
        DONE      = 3'd4
    } sd_xfer_state_t;

endpackage
`default_nettype wire

// File: rtl/sd_cmd_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sd_cmd_xfer_ctrl
// Description : Sequences one SD command transaction: shifts a 48-bit frame
//               MSB-first onto CMD, waits up to NCR_MAX bit times for a
//               response start bit, captures the response and reports the
//               result or a timeout. Drives the external bit/byte timer.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_cmd_xfer_ctrl
    import sd_ctrl_pkg::*;
#(
    parameter int CMD_BYTES = SD_CMD_BYTES,
    parameter int RESP_BITS = SD_RESP_BITS,
    parameter int NCR_MAX   = SD_NCR_MAX
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [8*CMD_BYTES-1:0] cmd_data,
    input  logic                   cmd_no_resp,
    output logic                   resp_valid,
    output logic                   resp_timeout,
    output logic [RESP_BITS-1:0]   resp_data,
    output logic                   busy,
    output logic                   timer_enable,
    output logic                   timer_clear_byte,
    input  logic                   shift_enable,
    input  logic                   byte_received,
    output logic                   sd_cmd_out,
    output logic                   sd_cmd_oe,
    input  logic                   sd_cmd_in
);

    localparam int c_CMD_BITS = 8 * CMD_BYTES;
    localparam int c_BYTE_W   = $clog2(CMD_BYTES + 1);
    localparam int c_WAIT_W   = $clog2(NCR_MAX + 1);
    localparam int c_BIT_W    = $clog2(RESP_BITS + 1);

    localparam logic [c_BYTE_W-1:0] c_BYTE_LAST = c_BYTE_W'(CMD_BYTES - 1);
    localparam logic [c_BYTE_W-1:0] c_BYTE_MAX  = c_BYTE_W'(CMD_BYTES);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX  = c_WAIT_W'(NCR_MAX);
    localparam logic [c_BIT_W-1:0]  c_BIT_MAX   = c_BIT_W'(RESP_BITS);

    sd_xfer_state_t          r_state;
    sd_xfer_state_t          w_state_nxt;

    logic [c_CMD_BITS-1:0]   r_tx_sr,    w_tx_sr_nxt;
    logic [RESP_BITS-1:0]    r_rx_sr,    w_rx_sr_nxt;
    logic [c_BYTE_W-1:0]     r_byte_cnt, w_byte_cnt_nxt;
    logic [c_WAIT_W-1:0]     r_wait_cnt, w_wait_cnt_nxt;
    logic [c_BIT_W-1:0]      r_bit_cnt,  w_bit_cnt_nxt;
    logic                    r_no_resp,  w_no_resp_nxt;
    logic                    r_timeout,  w_timeout_nxt;
    logic                    w_accept;
    logic                    w_nxt_active;

    // Next-state and datapath update for the transaction sequencer
    always_comb begin
        w_state_nxt    = r_state;
        w_tx_sr_nxt    = r_tx_sr;
        w_rx_sr_nxt    = r_rx_sr;
        w_byte_cnt_nxt = r_byte_cnt;
        w_wait_cnt_nxt = r_wait_cnt;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_no_resp_nxt  = r_no_resp;
        w_timeout_nxt  = r_timeout;
        w_accept       = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    w_accept       = 1'b1;
                    w_tx_sr_nxt    = cmd_data;
                    w_no_resp_nxt  = cmd_no_resp;
                    w_byte_cnt_nxt = '0;
                    w_timeout_nxt  = 1'b0;
                    w_state_nxt    = SEND;
                end
            end

            SEND: begin
                // Vacated low bits fill with 1 so the line idles high once
                // the frame has been fully shifted out.
                if (shift_enable) begin
                    w_tx_sr_nxt = {r_tx_sr[c_CMD_BITS-2:0], 1'b1};
                end
                if (byte_received) begin
                    if (r_byte_cnt != c_BYTE_MAX) begin
                        w_byte_cnt_nxt = r_byte_cnt + 1'b1;
                    end
                    if (r_byte_cnt == c_BYTE_LAST) begin
                        w_wait_cnt_nxt = '0;
                        w_state_nxt    = r_no_resp ? DONE : WAIT_RESP;
                    end
                end
            end

            WAIT_RESP: begin
                // A start bit takes priority over the final timeout strobe.
                if (shift_enable) begin
                    if (!sd_cmd_in) begin
                        w_rx_sr_nxt   = {r_rx_sr[RESP_BITS-2:0], 1'b0};
                        w_bit_cnt_nxt = c_BIT_W'(1);
                        w_state_nxt   = RECV;
                    end else begin
                        if (r_wait_cnt != c_WAIT_MAX) begin
                            w_wait_cnt_nxt = r_wait_cnt + 1'b1;
                        end
                        if (w_wait_cnt_nxt == c_WAIT_MAX) begin
                            w_timeout_nxt = 1'b1;
                            w_state_nxt   = DONE;
                        end
                    end
                end
            end

            RECV: begin
                if (shift_enable) begin
                    w_rx_sr_nxt = {r_rx_sr[RESP_BITS-2:0], sd_cmd_in};
                    if (r_bit_cnt != c_BIT_MAX) begin
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end
                    if (w_bit_cnt_nxt == c_BIT_MAX) begin
                        w_state_nxt = DONE;
                    end
                end
            end

            DONE: begin
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_nxt_active = (w_state_nxt == SEND) || (w_state_nxt == WAIT_RESP) ||
                          (w_state_nxt == RECV);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Shift registers, counters and per-transaction flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_sr    <= '1;
            r_rx_sr    <= '0;
            r_byte_cnt <= '0;
            r_wait_cnt <= '0;
            r_bit_cnt  <= '0;
            r_no_resp  <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_tx_sr    <= w_tx_sr_nxt;
            r_rx_sr    <= w_rx_sr_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_no_resp  <= w_no_resp_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    // Registered outputs, decoded from the state being entered so they line
    // up with r_state without an extra cycle of latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_ready        <= 1'b1;
            busy             <= 1'b0;
            timer_enable     <= 1'b0;
            timer_clear_byte <= 1'b0;
            sd_cmd_oe        <= 1'b0;
            sd_cmd_out       <= 1'b1;
            resp_valid       <= 1'b0;
            resp_timeout     <= 1'b0;
            resp_data        <= '0;
        end else begin
            cmd_ready        <= (w_state_nxt == IDLE);
            busy             <= (w_state_nxt != IDLE);
            timer_enable     <= w_nxt_active;
            timer_clear_byte <= w_accept || (w_state_nxt == DONE);
            sd_cmd_oe        <= (w_state_nxt == SEND);
            sd_cmd_out       <= (w_state_nxt == SEND) ? w_tx_sr_nxt[c_CMD_BITS-1] : 1'b1;
            resp_valid       <= (w_state_nxt == DONE);
            resp_timeout     <= (w_state_nxt == DONE) && w_timeout_nxt;
            if (w_state_nxt == DONE) begin
                resp_data <= (w_timeout_nxt || w_no_resp_nxt) ? '0 : w_rx_sr_nxt;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_cmd_xfer_ctrl
// Description : Self-checking bench for sd_cmd_xfer_ctrl with a timer model,
//               a scripted CMD-line responder and a transaction-level
//               reference model compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_cmd_xfer_ctrl;

    localparam int PH_IDLE   = 0;
    localparam int PH_TX     = 1;
    localparam int PH_LISTEN = 2;
    localparam int PH_RX     = 3;
    localparam int PH_END    = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [47:0] cmd_data = '0;
    logic        cmd_no_resp = 1'b0;
    logic        shift_enable = 1'b0;
    logic        byte_received = 1'b0;
    logic        sd_cmd_in = 1'b1;

    logic        cmd_ready, resp_valid, resp_timeout, busy;
    logic        timer_enable, timer_clear_byte, sd_cmd_out, sd_cmd_oe;
    logic [47:0] resp_data;

    sd_cmd_xfer_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_data         (cmd_data),
        .cmd_no_resp      (cmd_no_resp),
        .resp_valid       (resp_valid),
        .resp_timeout     (resp_timeout),
        .resp_data        (resp_data),
        .busy             (busy),
        .timer_enable     (timer_enable),
        .timer_clear_byte (timer_clear_byte),
        .shift_enable     (shift_enable),
        .byte_received    (byte_received),
        .sd_cmd_out       (sd_cmd_out),
        .sd_cmd_oe        (sd_cmd_oe),
        .sd_cmd_in        (sd_cmd_in)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    int          m_ph = PH_IDLE;
    bit          txq[$];
    bit          rxq[$];
    int          m_bytes = 0;
    int          m_wait = 0;
    bit          m_to = 1'b0;
    bit          m_nr = 1'b0;
    bit          m_acc = 1'b0;
    logic [47:0] m_hold = '0;
    int          gcyc = 0;
    int          cyc = 0;

    logic        exp_ready = 1'b1, exp_busy = 1'b0, exp_ten = 1'b0, exp_clr = 1'b0;
    logic        exp_oe = 1'b0, exp_out = 1'b1, exp_valid = 1'b0, exp_to = 1'b0;
    logic [47:0] exp_data = '0;

    always @(posedge clk) begin
        m_acc = 1'b0;
        if (rst) begin
            m_ph = PH_IDLE;
            txq.delete();
            rxq.delete();
            m_bytes = 0;
            m_wait  = 0;
            m_to    = 1'b0;
            m_nr    = 1'b0;
            m_hold  = '0;
        end else begin
            case (m_ph)
                PH_IDLE: if (cmd_valid) begin
                    txq.delete();
                    for (int i = 47; i >= 0; i--) txq.push_back(cmd_data[i]);
                    m_nr    = cmd_no_resp;
                    m_bytes = 0;
                    m_to    = 1'b0;
                    m_acc   = 1'b1;
                    m_ph    = PH_TX;
                end
                PH_TX: begin
                    if (shift_enable && txq.size() > 0) void'(txq.pop_front());
                    if (byte_received) begin
                        m_bytes++;
                        if (m_bytes == 6) begin
                            m_wait = 0;
                            rxq.delete();
                            m_ph = m_nr ? PH_END : PH_LISTEN;
                        end
                    end
                end
                PH_LISTEN: if (shift_enable) begin
                    if (!sd_cmd_in) begin
                        rxq.push_back(1'b0);
                        m_ph = PH_RX;
                    end else begin
                        m_wait++;
                        if (m_wait == 64) begin
                            m_to = 1'b1;
                            m_ph = PH_END;
                        end
                    end
                end
                PH_RX: if (shift_enable) begin
                    rxq.push_back(sd_cmd_in);
                    if (rxq.size() == 48) m_ph = PH_END;
                end
                default: m_ph = PH_IDLE;
            endcase
            if (m_ph == PH_END) begin
                logic [47:0] v;
                v = '0;
                foreach (rxq[i]) v = {v[46:0], rxq[i]};
                m_hold = (m_to || m_nr) ? 48'd0 : v;
            end
        end
        gcyc++;
        cyc = m_acc ? 1 : cyc + 1;
        exp_ready = (m_ph == PH_IDLE);
        exp_busy  = (m_ph != PH_IDLE);
        exp_ten   = (m_ph == PH_TX) || (m_ph == PH_LISTEN) || (m_ph == PH_RX);
        exp_clr   = m_acc || (m_ph == PH_END);
        exp_oe    = (m_ph == PH_TX);
        exp_out   = (m_ph == PH_TX && txq.size() > 0) ? txq[0] : 1'b1;
        exp_valid = (m_ph == PH_END);
        exp_to    = (m_ph == PH_END) && m_to;
        exp_data  = m_hold;
    end

    // ---------------- timer model and CMD-line responder ----------------
    int          tm_ph = 0;
    int          tm_sc = 0;
    bit          tm_pend = 1'b0;
    int          rsp_delay = 100000;
    logic [47:0] rsp_word = '1;
    int          rsp_idx = 0;

    function automatic logic rsp_bit(input int k);
        int j;
        if (k < rsp_delay) return 1'b1;
        j = k - rsp_delay;
        if (j < 48) return rsp_word[47-j];
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        #1;
        byte_received = tm_pend;
        tm_pend       = 1'b0;
        shift_enable  = 1'b0;
        if (!exp_ten || exp_clr) begin
            tm_ph = 0;
            tm_sc = 0;
            byte_received = 1'b0;
        end else begin
            tm_ph++;
            if (tm_ph == 8) begin
                tm_ph = 0;
                shift_enable = 1'b1;
                tm_sc++;
                if (tm_sc == 8) begin
                    tm_sc   = 0;
                    tm_pend = 1'b1;
                end
            end
        end
        sd_cmd_in = 1'b1;
        if (m_ph == PH_LISTEN || m_ph == PH_RX) begin
            if (shift_enable) begin
                sd_cmd_in = rsp_bit(rsp_idx);
                rsp_idx++;
            end
        end else begin
            rsp_idx = 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [47:0] cap = '0;
    int          dut_acc = 0;
    int          acc_g = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmd_ready", cmd_ready, exp_ready);
            chk("busy", busy, exp_busy);
            chk("timer_enable", timer_enable, exp_ten);
            chk("timer_clear_byte", timer_clear_byte, exp_clr);
            chk("sd_cmd_oe", sd_cmd_oe, exp_oe);
            chk("sd_cmd_out", sd_cmd_out, exp_out);
            chk("resp_valid", resp_valid, exp_valid);
            chk("resp_timeout", resp_timeout, exp_to);
            chk("resp_data", resp_data, exp_data);
            if (m_acc) cap = '0;
            if (shift_enable && m_ph == PH_TX) cap = {cap[46:0], sd_cmd_out};
            if (cmd_valid && cmd_ready) begin
                dut_acc++;
                acc_g = gcyc;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_cmd(input logic [47:0] d, input logic nr);
        cmd_data    = d;
        cmd_no_resp = nr;
        cmd_valid   = 1'b1;
        @(posedge clk); #1;
        cmd_valid   = 1'b0;
        cmd_data    = {$urandom, $urandom_range(65535, 0)} ;
        cmd_no_resp = ~nr;
    endtask

    // Returns in the cycle resp_valid is high, or reports a FAIL on budget.
    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (resp_valid) return;
        end
        tests++;
        fails++;
        $display("FAIL wait_resp_valid: got no pulse expected one within %0d cycles", budget);
    endtask

    initial begin
        int n;
        int g1;
        int acc0;

        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        @(posedge clk); #1;

        // T1: reset in the middle of SEND
        send_cmd(48'h40_0000_0000_95, 1'b0);
        repeat (30) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t1_cmd_ready", cmd_ready, 1);
        chk("t1_sd_cmd_oe", sd_cmd_oe, 0);
        chk("t1_timer_enable", timer_enable, 0);
        chk("t1_resp_valid", resp_valid, 0);
        n = 0;
        repeat (20) begin @(posedge clk); #1; if (resp_valid) n++; end
        chk("t1_no_resp_valid", n, 0);

        // T2: CMD0, no response expected
        send_cmd(48'h40_0000_0000_95, 1'b1);
        wait_done(2000);
        chk("t2_done_cycle", cyc, 387);
        chk("t2_timeout", resp_timeout, 0);
        chk("t2_resp_data", resp_data, 48'h0);
        chk("t2_line_bits", cap, 48'h40_0000_0000_95);
        @(posedge clk); #1;

        // T3: CMD8 with a response starting after 5 idle strobes
        rsp_delay = 5;
        rsp_word  = 48'h08_0000_01AA_87;
        send_cmd(48'h48_0000_01AA_87, 1'b0);
        wait_done(3000);
        chk("t3_done_cycle", cyc, 810);
        chk("t3_timeout", resp_timeout, 0);
        chk("t3_resp_data", resp_data, 48'h08_0000_01AA_87);
        chk("t3_line_bits", cap, 48'h48_0000_01AA_87);
        @(posedge clk); #1;

        // T4: silent card -> timeout after 64 strobes
        rsp_delay = 100000;
        send_cmd(48'h77_0000_0000_65, 1'b0);
        wait_done(3000);
        chk("t4_done_cycle", cyc, 898);
        chk("t4_timeout", resp_timeout, 1);
        chk("t4_resp_data", resp_data, 48'h0);
        @(posedge clk); #1;

        // T5: start bit lands on the 64th strobe
        rsp_delay = 63;
        rsp_word  = 48'h11_2233_4455_67;
        send_cmd(48'h51_0000_0010_55, 1'b0);
        wait_done(3000);
        chk("t5_done_cycle", cyc, 1274);
        chk("t5_timeout", resp_timeout, 0);
        chk("t5_resp_data", resp_data, 48'h11_2233_4455_67);
        @(posedge clk); #1;

        // T6: cmd_valid held high across a transaction
        acc0        = dut_acc;
        cmd_data    = 48'h40_0000_0000_95;
        cmd_no_resp = 1'b1;
        cmd_valid   = 1'b1;
        wait_done(2000);
        g1 = gcyc;
        wait_done(2000);
        cmd_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("t6_accepts", dut_acc - acc0, 2);
        chk("t6_reaccept_gap", acc_g - g1, 1);

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before 1000000");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
